// File: rtl/config_pkg.sv
// config_pkg: shared constants and types for the UART memory link.
package config_pkg;
  localparam logic [7:0] UART_CMD_READ  = 8'h72;
  localparam logic [7:0] UART_CMD_WRITE = 8'h77;
  localparam logic [7:0] UART_RESP_OK   = 8'hC8;
  typedef enum logic [3:0] {
    SRV_IDLE,
    SRV_RECV_LEN,
    SRV_RECV_ADDR,
    SRV_RECV_BE,
    SRV_RECV_DATA,
    SRV_MEM_REQ,
    SRV_MEM_WAIT,
    SRV_SEND_DATA,
    SRV_SEND_ACK
  } uart_srv_state_e;
endpackage

// File: rtl/uart.sv
// uart: 8N1 serialiser/deserialiser with stream-style byte ports; one bit lasts prescale*8 clocks.
module uart #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           prescale,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  txd
);
  localparam int FrameBits = DATA_WIDTH + 2;
  logic [18:0] bit_len, half_len, tx_tmr_q, rx_tmr_q;
  logic [3:0] tx_bits_q, rx_bits_q;
  logic [FrameBits-1:0] tx_sh_q;
  logic [DATA_WIDTH-1:0] rx_sh_q;
  logic [1:0] rxd_q;
  assign bit_len = {prescale, 3'b000} - 19'd1;
  assign half_len = {1'b0, prescale, 2'b00} - 19'd1;
  assign s_axis_tready = tx_bits_q == '0;
  assign txd = tx_sh_q[0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sh_q <= '1;
      tx_bits_q <= '0;
      tx_tmr_q <= '0;
    end else if (s_axis_tvalid && s_axis_tready) begin
      tx_sh_q <= {1'b1, s_axis_tdata, 1'b0};
      tx_bits_q <= 4'(FrameBits);
      tx_tmr_q <= bit_len;
    end else if (tx_bits_q != '0) begin
      if (tx_tmr_q == '0) begin
        tx_sh_q <= {1'b1, tx_sh_q[FrameBits-1:1]};
        tx_bits_q <= tx_bits_q - 4'd1;
        tx_tmr_q <= bit_len;
      end else begin
        tx_tmr_q <= tx_tmr_q - 19'd1;
      end
    end
  end
  // Receiver samples mid-bit: half a bit after the start edge, then every full bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_q <= '1;
      rx_bits_q <= '0;
      rx_tmr_q <= '0;
      rx_sh_q <= '0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      rxd_q <= {rxd_q[0], rxd};
      if (m_axis_tready) m_axis_tvalid <= 1'b0;
      if (rx_bits_q == '0) begin
        if (!rxd_q[1]) begin
          rx_bits_q <= 4'(FrameBits);
          rx_tmr_q <= half_len;
        end
      end else if (rx_tmr_q != '0) begin
        rx_tmr_q <= rx_tmr_q - 19'd1;
      end else begin
        rx_tmr_q <= bit_len;
        rx_bits_q <= rx_bits_q - 4'd1;
        if (rx_bits_q == 4'(FrameBits)) begin
          if (rxd_q[1]) rx_bits_q <= '0;
        end else if (rx_bits_q == 4'd1) begin
          if (rxd_q[1]) begin
            m_axis_tdata <= rx_sh_q;
            m_axis_tvalid <= 1'b1;
          end
        end else begin
          rx_sh_q <= {rxd_q[1], rx_sh_q[DATA_WIDTH-1:1]};
        end
      end
    end
  end
endmodule

// File: rtl/uart_mem_server.sv
// uart_mem_server: parses read/write command frames from the UART and drives a word memory port.
module uart_mem_server
  import config_pkg::*;
#(
  parameter int ClkFreq       = 12000000,
  parameter int BaudRate      = 115200,
  parameter int TimeoutCycles = 1000000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        frame_err_o
);
  localparam int Prescale = ClkFreq / (BaudRate * 8);
  uart_srv_state_e state_q;
  logic [1:0] rst_sync_q, byte_q;
  logic rst_n, rx_v, tx_ready, tx_valid, recv, we_q, valid_q, err_q;
  logic [7:0] rx_d, tx_data, len_q, xfer_q;
  logic [31:0] addr_q, wdata_q, rdata_q, tmr_q;
  logic [3:0] wstrb_q;
  // Reset asserts asynchronously but leaves on a clock edge.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];
  assign recv = state_q inside {SRV_RECV_LEN, SRV_RECV_ADDR, SRV_RECV_BE, SRV_RECV_DATA};
  assign tx_valid = state_q inside {SRV_SEND_DATA, SRV_SEND_ACK};
  assign tx_data = state_q == SRV_SEND_ACK ? UART_RESP_OK : rdata_q[{byte_q, 3'b000} +: 8];
  assign mem_valid_o = valid_q;
  assign mem_we_o = we_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign frame_err_o = err_q;
  uart #(.DATA_WIDTH(8)) u_uart (
    .clk(clk_i),
    .rst(~rst_n),
    .prescale(16'(Prescale)),
    .s_axis_tdata(tx_data),
    .s_axis_tvalid(tx_valid),
    .s_axis_tready(tx_ready),
    .m_axis_tdata(rx_d),
    .m_axis_tvalid(rx_v),
    .m_axis_tready(1'b1),
    .rxd(rx_i),
    .txd(tx_o)
  );
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SRV_IDLE;
      byte_q <= '0;
      we_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      len_q <= '0;
      xfer_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wstrb_q <= '0;
      tmr_q <= '0;
    end else begin
      err_q <= 1'b0;
      tmr_q <= (rx_v || !recv) ? '0 : tmr_q + 32'd1;
      if (recv && !rx_v && tmr_q == 32'(TimeoutCycles - 1)) begin
        err_q <= 1'b1;
        state_q <= SRV_IDLE;
      end else begin
        case (state_q)
          SRV_IDLE: if (rx_v) begin
            if (rx_d == UART_CMD_READ || rx_d == UART_CMD_WRITE) begin
              we_q <= rx_d == UART_CMD_WRITE;
              wstrb_q <= '0;
              state_q <= SRV_RECV_LEN;
            end else begin
              err_q <= 1'b1;
            end
          end
          SRV_RECV_LEN: if (rx_v) begin
            len_q <= rx_d;
            byte_q <= '0;
            xfer_q <= '0;
            state_q <= SRV_RECV_ADDR;
          end
          SRV_RECV_ADDR: if (rx_v) begin
            addr_q[{byte_q, 3'b000} +: 8] <= rx_d;
            byte_q <= byte_q + 2'd1;
            if (byte_q == 2'd3) begin
              addr_q[1:0] <= 2'b00;
              valid_q <= !we_q;
              state_q <= we_q ? SRV_RECV_BE : SRV_MEM_REQ;
            end
          end
          SRV_RECV_BE: if (rx_v) begin
            wstrb_q <= rx_d[3:0];
            byte_q <= '0;
            state_q <= SRV_RECV_DATA;
          end
          SRV_RECV_DATA: if (rx_v) begin
            wdata_q[{byte_q, 3'b000} +: 8] <= rx_d;
            byte_q <= byte_q + 2'd1;
            if (byte_q == 2'd3) begin
              valid_q <= 1'b1;
              state_q <= SRV_MEM_REQ;
            end
          end
          SRV_MEM_REQ: if (mem_ready_i) begin
            valid_q <= 1'b0;
            byte_q <= '0;
            rdata_q <= mem_rdata_i;
            // Read data may return in the very cycle the request is accepted.
            state_q <= we_q ? SRV_SEND_ACK : (mem_rvalid_i ? SRV_SEND_DATA : SRV_MEM_WAIT);
          end
          SRV_MEM_WAIT: if (mem_rvalid_i) begin
            rdata_q <= mem_rdata_i;
            state_q <= SRV_SEND_DATA;
          end
          SRV_SEND_DATA: if (tx_ready) begin
            byte_q <= byte_q + 2'd1;
            if (byte_q == 2'd3) begin
              xfer_q <= xfer_q + 8'd1;
              state_q <= xfer_q == len_q ? SRV_IDLE : SRV_RECV_ADDR;
            end
          end
          SRV_SEND_ACK: if (tx_ready) begin
            xfer_q <= xfer_q + 8'd1;
            addr_q <= addr_q + 32'd4;
            state_q <= xfer_q == len_q ? SRV_IDLE : SRV_RECV_BE;
          end
          default: state_q <= SRV_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_mem_server.sv
// tb_uart_mem_server: random command frames against a word-memory reference model with queued expectations.
module tb_uart_mem_server;
  import config_pkg::*;
  localparam int T = 400;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } mreq_t;
  logic clk_i = 1'b0, reset_ni = 1'b0, rx_i = 1'b1, tx_o;
  logic mem_valid_o, mem_ready_i = 1'b0, mem_we_o, mem_rvalid_i = 1'b0, frame_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
  logic [3:0] mem_wstrb_o;
  int compared = 0, mismatched = 0, exp_err = 0, cyc = 0, err_cyc = 0;
  mreq_t exp_mem[$];
  logic [7:0] exp_tx[$], wq_be[$];
  logic [31:0] wq_d[$];
  logic [31:0] phys[logic [31:0]], refm[logic [31:0]];
  bit hold_ready = 0, force_stall = 0, prev_v = 0, rd_pend = 0;
  int stall = 0, rd_dly = 0;
  logic [31:0] rd_data;
  mreq_t snap, e;
  uart_mem_server #(.ClkFreq(800), .BaudRate(100), .TimeoutCycles(T)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .rx_i(rx_i), .tx_o(tx_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .frame_err_o(frame_err_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  function automatic void chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_word(a);
  endfunction
  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : init_word(a);
  endfunction
  function automatic void ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = ref_rd(a);
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    refm[a] = w;
  endfunction
  function automatic void preload(input logic [31:0] a, input logic [31:0] v);
    refm[a] = v;
    phys[a] = v;
  endfunction
  function automatic logic [31:0] rand_addr();
    return 32'h3000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
  endfunction
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(negedge clk_i);
    rx_i = 1'b0;
    repeat (8) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (8) @(negedge clk_i);
    end
    rx_i = 1'b1;
    repeat (8) @(negedge clk_i);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask
  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_mem.size() != 0) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    compared++;
    if (n >= 3000) begin
      mismatched++;
      $display("FAIL drain_%s: %0d tx bytes and %0d mem ops outstanding, required 0", tag, exp_tx.size(), exp_mem.size());
      exp_tx.delete();
      exp_mem.delete();
    end
  endtask
  task automatic read_frame(input logic [7:0] len, input logic [31:0] a0, input bit seq);
    logic [31:0] a, w;
    send_byte(UART_CMD_READ);
    send_byte(len);
    for (int t = 0; t <= int'(len); t++) begin
      a = seq ? a0 + 32'(4 * t) : (t == 0 ? a0 : rand_addr());
      w = ref_rd({a[31:2], 2'b00});
      exp_mem.push_back('{1'b0, {a[31:2], 2'b00}, 32'h0, 4'h0});
      for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
      send_word(a);
      wait_drain("rd");
    end
  endtask
  task automatic write_frame(input logic [7:0] len, input logic [31:0] a0);
    logic [31:0] a, d;
    logic [7:0] be;
    send_byte(UART_CMD_WRITE);
    send_byte(len);
    send_word(a0);
    a = {a0[31:2], 2'b00};
    for (int t = 0; t <= int'(len); t++) begin
      be = wq_be.size() != 0 ? wq_be.pop_front() : 8'($urandom);
      d = wq_d.size() != 0 ? wq_d.pop_front() : $urandom;
      exp_mem.push_back('{1'b1, a, d, be[3:0]});
      ref_wr(a, d, be[3:0]);
      exp_tx.push_back(UART_RESP_OK);
      send_byte(be);
      send_word(d);
      wait_drain("wr");
      a = a + 32'd4;
    end
  endtask
  // Memory responder and request monitor: inputs for the coming edge are set on the falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      if (rd_pend) begin
        if (rd_dly == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = rd_data;
          rd_pend = 0;
        end else rd_dly--;
      end
      if (mem_valid_o && !prev_v) begin
        snap = '{mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o};
        stall = (force_stall || $urandom_range(0, 3) == 0) ? 10 : 0;
        force_stall = 0;
      end
      prev_v = mem_valid_o;
      if (hold_ready || stall > 0) begin
        mem_ready_i = 1'b0;
        if (stall > 0) stall--;
      end else mem_ready_i = $urandom_range(0, 2) != 0;
      if (mem_valid_o && mem_ready_i) begin
        chk("req_stable", {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}, snap);
        if (exp_mem.size() == 0) chk("mem_unexpected", {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}, 69'h0);
        else begin
          e = exp_mem.pop_front();
          chk("mem_we", 69'(mem_we_o), 69'(e.we));
          chk("mem_addr", 69'(mem_addr_o), 69'(e.addr));
          chk("mem_wstrb", 69'(mem_wstrb_o), 69'(e.be));
          if (e.we) chk("mem_wdata", 69'(mem_wdata_o), 69'(e.data));
        end
        if (mem_we_o) begin
          rd_data = phys_rd(mem_addr_o);
          for (int i = 0; i < 4; i++) if (mem_wstrb_o[i]) rd_data[8*i +: 8] = mem_wdata_o[8*i +: 8];
          phys[mem_addr_o] = rd_data;
        end else begin
          rd_data = phys_rd(mem_addr_o);
          rd_dly = $urandom_range(0, 3);
          if (rd_dly == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = rd_data;
          end else begin
            rd_dly--;
            rd_pend = 1;
          end
        end
      end
    end
  end
  // UART transmit monitor: decodes tx_o sampling each bit near its middle.
  initial begin
    logic [7:0] b;
    logic [7:0] x;
    forever begin
      @(negedge clk_i);
      if (reset_ni && tx_o == 1'b0) begin
        repeat (4) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(negedge clk_i);
          b[i] = tx_o;
        end
        repeat (8) @(negedge clk_i);
        x = exp_tx.size() != 0 ? exp_tx.pop_front() : 8'hxx;
        chk("tx_byte", {tx_o, b}, {1'b1, x});
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk_i);
      if (frame_err_o) begin
        err_cyc = cyc;
        if (exp_err > 0) begin
          compared++;
          exp_err--;
        end else chk("frame_err_unexpected", 69'd1, 69'd0);
      end
    end
  end
  initial begin
    repeat (95000) @(posedge clk_i);
    mismatched++;
    $display("FAIL watchdog: cycle budget exhausted");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end
  initial begin
    int t0, d, n;
    repeat (3) @(negedge clk_i);
    chk("rst_valid", 69'(mem_valid_o), 69'd0);
    chk("rst_we", 69'(mem_we_o), 69'd0);
    chk("rst_addr", 69'(mem_addr_o), 69'd0);
    chk("rst_wdata", 69'(mem_wdata_o), 69'd0);
    chk("rst_wstrb", 69'(mem_wstrb_o), 69'd0);
    chk("rst_err", 69'(frame_err_o), 69'd0);
    chk("rst_tx", 69'(tx_o), 69'd1);
    reset_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    preload(32'h1000, 32'hDEADBEEF);
    read_frame(8'd0, 32'h1000, 0);
    preload(32'h100, 32'h11111111);
    preload(32'h104, 32'h22222222);
    read_frame(8'd1, 32'h100, 1);
    wq_be.push_back(8'h0F);
    wq_be.push_back(8'h03);
    wq_d.push_back(32'h44332211);
    wq_d.push_back(32'hAABBCCDD);
    force_stall = 1;
    write_frame(8'd1, 32'h200);
    read_frame(8'd1, 32'h200, 1);
    exp_err++;
    send_byte(8'h55);
    read_frame(8'd0, 32'h1000, 0);
    exp_err++;
    send_byte(UART_CMD_READ);
    send_byte(8'd0);
    send_byte(8'h34);
    send_byte(8'h12);
    t0 = cyc;
    n = 0;
    while (exp_err != 0 && n < T + 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("timeout_err_seen", 69'(exp_err), 69'd0);
    d = err_cyc - t0;
    compared++;
    if (d < T - 4 || d > T + 4) begin
      mismatched++;
      $display("FAIL timeout_delay: got %0d cycles after last byte, required about %0d", d, T);
    end
    read_frame(8'd0, 32'h104, 0);
    write_frame(8'd1, 32'hFFFFFFFE);
    read_frame(8'd1, 32'hFFFFFFFC, 1);
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        exp_err++;
        d = $urandom_range(0, 255);
        send_byte((d == 32'h72 || d == 32'h77) ? 8'h00 : 8'(d));
      end
      if ($urandom_range(0, 1) != 0) write_frame(8'($urandom_range(0, 2)), rand_addr());
      else read_frame(8'($urandom_range(0, 2)), rand_addr(), 0);
    end
    hold_ready = 1;
    send_byte(UART_CMD_WRITE);
    send_byte(8'd0);
    send_word(32'h400);
    send_byte(8'h0F);
    send_word(32'h12345678);
    n = 0;
    while (!mem_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("rst_mid_req_seen", 69'(mem_valid_o), 69'd1);
    repeat (3) @(negedge clk_i);
    reset_ni = 1'b0;
    #1;
    chk("rst_mid_valid", 69'(mem_valid_o), 69'd0);
    chk("rst_mid_tx", 69'(tx_o), 69'd1);
    chk("rst_mid_addr", 69'(mem_addr_o), 69'd0);
    repeat (3) @(negedge clk_i);
    reset_ni = 1'b1;
    hold_ready = 0;
    repeat (5) @(negedge clk_i);
    read_frame(8'd0, 32'h400, 0);
    wait_drain("final");
    repeat (20) @(negedge clk_i);
    chk("err_pending", 69'(exp_err), 69'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
